// File: rtl/control_pipeline.sv
// Purpose: decodes the ID-stage opcode into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB with load-use and branch-flush handling.
// Latency: EX_* 1 cycle after ID, MEM_* 2 cycles, WB_* 3 cycles; Stall/Flush are combinational.
// Backpressure: only Stall (hold PC and IF/ID on a load-use hazard); EX/MEM and MEM/WB always advance.
module control_pipeline #(
    parameter int REG_W        = 5,
    parameter int LINK_REG     = 30,
    parameter int ZERO_REG     = 31,
    parameter int BRANCH_STAGE = 2,
    parameter int SCNT_W       = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              ID_Valid,
    input  logic [10:0]       Opcode,
    input  logic [REG_W-1:0]  Rn,
    input  logic [REG_W-1:0]  Rs2,
    input  logic [REG_W-1:0]  Rd,
    input  logic              BranchTaken,
    output logic              Stall,
    output logic              Flush,
    output logic              EX_Valid,
    output logic              EX_ALUSrc,
    output logic              EX_IllegalOp,
    output logic [1:0]        EX_ALUOp,
    output logic [REG_W-1:0]  EX_Rd,
    output logic              MEM_Valid,
    output logic              MEM_MemRead,
    output logic              MEM_MemWrite,
    output logic              MEM_Branch,
    output logic              MEM_Uncondbranch,
    output logic              MEM_CBNZSig,
    output logic              WB_Valid,
    output logic              WB_RegWrite,
    output logic              WB_MemToReg,
    output logic              WB_BL,
    output logic [REG_W-1:0]  WB_Rd,
    output logic [SCNT_W-1:0] StallCount
);

    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);
    localparam logic [REG_W-1:0] LR = REG_W'(LINK_REG);
    // A branch resolving in MEM means the instruction now in EX is wrong-path too.
    localparam logic KILL_EX_ON_FLUSH = (BRANCH_STAGE == 2);

    // Full control bundle as produced by decode and held in ID/EX.
    typedef struct packed {
        logic       alusrc;
        logic [1:0] aluop;
        logic       illegal;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       uncond;
        logic       cbnz;
        logic       regwrite;
        logic       memtoreg;
        logic       bl;
    } ctrl_t;

    // Controls still needed from MEM onwards.
    typedef struct packed {
        logic memread;
        logic memwrite;
        logic branch;
        logic uncond;
        logic cbnz;
        logic regwrite;
        logic memtoreg;
        logic bl;
    } mem_ctrl_t;

    // Controls still needed in WB.
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic bl;
    } wb_ctrl_t;

    ctrl_t            dec;
    logic             uses_rn;
    logic             uses_rs2;
    logic [REG_W-1:0] dec_rd;

    logic             ex_valid;
    ctrl_t            ex_ctrl;
    logic [REG_W-1:0] ex_rd;

    logic             mem_valid;
    mem_ctrl_t        mem_ctrl;
    logic [REG_W-1:0] mem_rd;

    logic             wb_valid;
    wb_ctrl_t         wb_ctrl;
    logic [REG_W-1:0] wb_rd;

    logic             load_use;
    logic             id_accept;
    logic             mem_accept;
    logic [SCNT_W-1:0] stall_cnt;

    // Opcode decode, first matching pattern wins; anything unmatched is illegal.
    always_comb begin
        dec      = '0;
        uses_rn  = 1'b0;
        uses_rs2 = 1'b0;
        dec_rd   = Rd;
        casez (Opcode)
            11'b000101?????: begin
                dec.uncond = 1'b1;
            end
            11'b100101?????: begin
                dec.uncond   = 1'b1;
                dec.bl       = 1'b1;
                dec.regwrite = 1'b1;
                dec_rd       = LR;
            end
            11'b10110100???: begin
                dec.branch = 1'b1;
                dec.aluop  = 2'b01;
                uses_rs2   = 1'b1;
            end
            11'b10110101???: begin
                dec.cbnz  = 1'b1;
                dec.aluop = 2'b01;
                uses_rs2  = 1'b1;
            end
            11'b1101001101?: begin
                dec.alusrc   = 1'b1;
                dec.aluop    = 2'b10;
                dec.regwrite = 1'b1;
                uses_rn      = 1'b1;
            end
            11'b?0?1000100?: begin
                dec.alusrc   = 1'b1;
                dec.aluop    = 2'b10;
                dec.regwrite = 1'b1;
                uses_rn      = 1'b1;
            end
            11'b1??0101?000: begin
                dec.aluop    = 2'b10;
                dec.regwrite = 1'b1;
                uses_rn      = 1'b1;
                uses_rs2     = 1'b1;
            end
            11'b11111000010: begin
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
                uses_rn      = 1'b1;
            end
            11'b11111000000: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                uses_rn      = 1'b1;
                uses_rs2     = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Load-use detection against the load sitting in EX; XZR never creates a dependency.
    always_comb begin
        load_use = ID_Valid & ex_valid & ex_ctrl.memread & (ex_rd != ZR) &
                   ((uses_rn & (ex_rd == Rn)) | (uses_rs2 & (ex_rd == Rs2)));
    end

    // Flush outranks the hazard; both are silenced while Reset is asserted.
    assign Stall      = load_use & ~BranchTaken & ~Reset;
    assign Flush      = BranchTaken & ~Reset;
    assign id_accept  = ID_Valid & ~load_use & ~BranchTaken;
    assign mem_accept = ex_valid & ~(KILL_EX_ON_FLUSH & BranchTaken);

    // ID/EX register: bubbles carry zeroed controls, Rd keeps its last valid value.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_rd    <= '0;
        end else begin
            ex_valid <= id_accept;
            if (id_accept) begin
                ex_ctrl <= dec;
                ex_rd   <= dec_rd;
            end else begin
                ex_ctrl <= '0;
            end
        end
    end

    // EX/MEM register: always advances, optionally squashing the wrong-path EX instruction.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            mem_valid <= 1'b0;
            mem_ctrl  <= '0;
            mem_rd    <= '0;
        end else begin
            mem_valid <= mem_accept;
            if (mem_accept) begin
                mem_ctrl.memread  <= ex_ctrl.memread;
                mem_ctrl.memwrite <= ex_ctrl.memwrite;
                mem_ctrl.branch   <= ex_ctrl.branch;
                mem_ctrl.uncond   <= ex_ctrl.uncond;
                mem_ctrl.cbnz     <= ex_ctrl.cbnz;
                mem_ctrl.regwrite <= ex_ctrl.regwrite;
                mem_ctrl.memtoreg <= ex_ctrl.memtoreg;
                mem_ctrl.bl       <= ex_ctrl.bl;
                mem_rd            <= ex_rd;
            end else begin
                mem_ctrl <= '0;
            end
        end
    end

    // MEM/WB register: register writes to XZR are dropped here.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            wb_valid <= 1'b0;
            wb_ctrl  <= '0;
            wb_rd    <= '0;
        end else begin
            wb_valid <= mem_valid;
            if (mem_valid) begin
                wb_ctrl.regwrite <= mem_ctrl.regwrite & (mem_rd != ZR);
                wb_ctrl.memtoreg <= mem_ctrl.memtoreg;
                wb_ctrl.bl       <= mem_ctrl.bl;
                wb_rd            <= mem_rd;
            end else begin
                wb_ctrl <= '0;
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            stall_cnt <= '0;
        end else if (Stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign EX_Valid         = ex_valid;
    assign EX_ALUSrc        = ex_ctrl.alusrc;
    assign EX_IllegalOp     = ex_ctrl.illegal;
    assign EX_ALUOp         = ex_ctrl.aluop;
    assign EX_Rd            = ex_rd;
    assign MEM_Valid        = mem_valid;
    assign MEM_MemRead      = mem_ctrl.memread;
    assign MEM_MemWrite     = mem_ctrl.memwrite;
    assign MEM_Branch       = mem_ctrl.branch;
    assign MEM_Uncondbranch = mem_ctrl.uncond;
    assign MEM_CBNZSig      = mem_ctrl.cbnz;
    assign WB_Valid         = wb_valid;
    assign WB_RegWrite      = wb_ctrl.regwrite;
    assign WB_MemToReg      = wb_ctrl.memtoreg;
    assign WB_BL            = wb_ctrl.bl;
    assign WB_Rd            = wb_rd;
    assign StallCount       = stall_cnt;

endmodule

// File: tb/tb_control_pipeline.sv
// Purpose: scoreboard bench for control_pipeline (default build plus a 2-bit stall-counter build).
// Latency: expectations queued at issue, compared as each stage reports Valid.
// Backpressure: stalled issues are re-presented and only the accepted copy is queued.
module tb_control_pipeline;

    logic        CLK = 1'b0;
    logic        Reset, ID_Valid, BranchTaken;
    logic [10:0] Opcode;
    logic [4:0]  Rn, Rs2, Rd;

    logic        Stall, Flush, EX_Valid, EX_ALUSrc, EX_IllegalOp;
    logic [1:0]  EX_ALUOp;
    logic [4:0]  EX_Rd, WB_Rd;
    logic        MEM_Valid, MEM_MemRead, MEM_MemWrite, MEM_Branch, MEM_Uncondbranch, MEM_CBNZSig;
    logic        WB_Valid, WB_RegWrite, WB_MemToReg, WB_BL;
    logic [15:0] StallCount;

    logic        s_stall, s_flush, s_ex_valid, s_ex_alusrc, s_ex_illegal;
    logic [1:0]  s_ex_aluop;
    logic [4:0]  s_ex_rd, s_wb_rd;
    logic        s_mem_valid, s_mem_memread, s_mem_memwrite, s_mem_branch, s_mem_uncond, s_mem_cbnz;
    logic        s_wb_valid, s_wb_regwrite, s_wb_memtoreg, s_wb_bl;
    logic [1:0]  s_stall_count;

    control_pipeline dut (
        .CLK(CLK), .Reset(Reset), .ID_Valid(ID_Valid), .Opcode(Opcode), .Rn(Rn), .Rs2(Rs2), .Rd(Rd),
        .BranchTaken(BranchTaken), .Stall(Stall), .Flush(Flush), .EX_Valid(EX_Valid),
        .EX_ALUSrc(EX_ALUSrc), .EX_IllegalOp(EX_IllegalOp), .EX_ALUOp(EX_ALUOp), .EX_Rd(EX_Rd),
        .MEM_Valid(MEM_Valid), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_Branch(MEM_Branch), .MEM_Uncondbranch(MEM_Uncondbranch), .MEM_CBNZSig(MEM_CBNZSig),
        .WB_Valid(WB_Valid), .WB_RegWrite(WB_RegWrite), .WB_MemToReg(WB_MemToReg), .WB_BL(WB_BL),
        .WB_Rd(WB_Rd), .StallCount(StallCount)
    );

    control_pipeline #(.SCNT_W(2)) dut_s (
        .CLK(CLK), .Reset(Reset), .ID_Valid(ID_Valid), .Opcode(Opcode), .Rn(Rn), .Rs2(Rs2), .Rd(Rd),
        .BranchTaken(BranchTaken), .Stall(s_stall), .Flush(s_flush), .EX_Valid(s_ex_valid),
        .EX_ALUSrc(s_ex_alusrc), .EX_IllegalOp(s_ex_illegal), .EX_ALUOp(s_ex_aluop), .EX_Rd(s_ex_rd),
        .MEM_Valid(s_mem_valid), .MEM_MemRead(s_mem_memread), .MEM_MemWrite(s_mem_memwrite),
        .MEM_Branch(s_mem_branch), .MEM_Uncondbranch(s_mem_uncond), .MEM_CBNZSig(s_mem_cbnz),
        .WB_Valid(s_wb_valid), .WB_RegWrite(s_wb_regwrite), .WB_MemToReg(s_wb_memtoreg), .WB_BL(s_wb_bl),
        .WB_Rd(s_wb_rd), .StallCount(s_stall_count)
    );

    always #5 CLK = ~CLK;

    // ex = {alusrc, aluop, illegal, rd}; mem = {memread, memwrite, branch, uncond, cbnz}; wb = {regwrite, memtoreg, bl, rd}
    typedef struct {
        logic [10:0] op;
        logic [4:0]  rn, rs2, rd;
        logic [8:0]  ex;
        logic [4:0]  mem;
        logic [7:0]  wb;
    } ins_t;

    logic [8:0] q_ex[$];
    logic [4:0] q_mem[$];
    logic [7:0] q_wb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ins_t mk(input logic [10:0] op, input logic [4:0] rn, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [8:0] ex, input logic [4:0] mem,
                                input logic [7:0] wb);
        ins_t i;
        i.op = op; i.rn = rn; i.rs2 = rs2; i.rd = rd; i.ex = ex; i.mem = mem; i.wb = wb;
        return i;
    endfunction

    // Present one instruction for one cycle; queue expectations only for the stages it will reach.
    task automatic issue(input ins_t i, input bit pe, input bit pm, input bit pw, input bit br);
        @(posedge CLK); #1;
        ID_Valid = 1'b1; Opcode = i.op; Rn = i.rn; Rs2 = i.rs2; Rd = i.rd; BranchTaken = br;
        if (pe) q_ex.push_back(i.ex);
        if (pm) q_mem.push_back(i.mem);
        if (pw) q_wb.push_back(i.wb);
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK); #1;
            ID_Valid = 1'b0; BranchTaken = 1'b0;
            @(negedge CLK);
        end
    endtask

    // Scoreboard monitor: each valid stage pops its expectation, invalid stages must show zero controls.
    always @(negedge CLK) begin
        if (!Reset) begin
            if (EX_Valid) begin
                if (q_ex.size() == 0) chk("ex_unexpected", 1, 0);
                else chk("ex_sb", {EX_ALUSrc, EX_ALUOp, EX_IllegalOp, EX_Rd}, q_ex.pop_front());
            end else chk("ex_gated", {EX_ALUSrc, EX_ALUOp, EX_IllegalOp}, 0);
            if (MEM_Valid) begin
                if (q_mem.size() == 0) chk("mem_unexpected", 1, 0);
                else chk("mem_sb", {MEM_MemRead, MEM_MemWrite, MEM_Branch, MEM_Uncondbranch, MEM_CBNZSig},
                         q_mem.pop_front());
            end else chk("mem_gated", {MEM_MemRead, MEM_MemWrite, MEM_Branch, MEM_Uncondbranch, MEM_CBNZSig}, 0);
            if (WB_Valid) begin
                if (q_wb.size() == 0) chk("wb_unexpected", 1, 0);
                else chk("wb_sb", {WB_RegWrite, WB_MemToReg, WB_BL, WB_Rd}, q_wb.pop_front());
            end else chk("wb_gated", {WB_RegWrite, WB_MemToReg, WB_BL}, 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        ins_t ld3, ld5, ld5d, ld12, ld31, add5, add31, cbz, cbnz, stur, stur12, addi, lsl, b0, b12, bl7, ill;
        ld3    = mk(11'b11111000010, 5'd0,  5'd0,  5'd3,  {1'b1, 2'b00, 1'b0, 5'd3},  5'b10000, {3'b110, 5'd3});
        ld5    = mk(11'b11111000010, 5'd0,  5'd0,  5'd5,  {1'b1, 2'b00, 1'b0, 5'd5},  5'b10000, {3'b110, 5'd5});
        ld5d   = mk(11'b11111000010, 5'd5,  5'd0,  5'd5,  {1'b1, 2'b00, 1'b0, 5'd5},  5'b10000, {3'b110, 5'd5});
        ld12   = mk(11'b11111000010, 5'd0,  5'd0,  5'd12, {1'b1, 2'b00, 1'b0, 5'd12}, 5'b10000, {3'b110, 5'd12});
        ld31   = mk(11'b11111000010, 5'd0,  5'd0,  5'd31, {1'b1, 2'b00, 1'b0, 5'd31}, 5'b10000, {3'b010, 5'd31});
        add5   = mk(11'b10001011000, 5'd5,  5'd0,  5'd6,  {1'b0, 2'b10, 1'b0, 5'd6},  5'b00000, {3'b100, 5'd6});
        add31  = mk(11'b10001011000, 5'd31, 5'd0,  5'd8,  {1'b0, 2'b10, 1'b0, 5'd8},  5'b00000, {3'b100, 5'd8});
        cbz    = mk(11'b10110100000, 5'd0,  5'd0,  5'd1,  {1'b0, 2'b01, 1'b0, 5'd1},  5'b00100, {3'b000, 5'd1});
        cbnz   = mk(11'b10110101000, 5'd0,  5'd0,  5'd2,  {1'b0, 2'b01, 1'b0, 5'd2},  5'b00001, {3'b000, 5'd2});
        stur   = mk(11'b11111000000, 5'd0,  5'd0,  5'd3,  {1'b1, 2'b00, 1'b0, 5'd3},  5'b01000, {3'b000, 5'd3});
        stur12 = mk(11'b11111000000, 5'd0,  5'd12, 5'd0,  {1'b1, 2'b00, 1'b0, 5'd0},  5'b01000, {3'b000, 5'd0});
        addi   = mk(11'b10010001000, 5'd0,  5'd0,  5'd4,  {1'b1, 2'b10, 1'b0, 5'd4},  5'b00000, {3'b100, 5'd4});
        lsl    = mk(11'b11010011011, 5'd0,  5'd0,  5'd5,  {1'b1, 2'b10, 1'b0, 5'd5},  5'b00000, {3'b100, 5'd5});
        b0     = mk(11'b00010100000, 5'd0,  5'd0,  5'd6,  {1'b0, 2'b00, 1'b0, 5'd6},  5'b00010, {3'b000, 5'd6});
        b12    = mk(11'b00010100000, 5'd12, 5'd12, 5'd0,  {1'b0, 2'b00, 1'b0, 5'd0},  5'b00010, {3'b000, 5'd0});
        bl7    = mk(11'b10010100000, 5'd0,  5'd0,  5'd7,  {1'b0, 2'b00, 1'b0, 5'd30}, 5'b00010, {3'b101, 5'd30});
        ill    = mk(11'b00000000000, 5'd0,  5'd0,  5'd9,  {1'b0, 2'b00, 1'b1, 5'd9},  5'b00000, {3'b000, 5'd9});

        // Reset: Flush held low even with BranchTaken, everything cleared.
        Reset = 1'b1; ID_Valid = 1'b0; BranchTaken = 1'b0; Opcode = '0; Rn = '0; Rs2 = '0; Rd = '0;
        repeat (2) @(posedge CLK);
        #1 BranchTaken = 1'b1;
        @(negedge CLK);
        chk("flush_in_reset", Flush, 0);
        @(posedge CLK); #1;
        BranchTaken = 1'b0;
        chk("reset_outs", {Stall, Flush, EX_Valid, EX_ALUSrc, EX_IllegalOp, EX_ALUOp, EX_Rd, MEM_Valid,
                           MEM_MemRead, MEM_MemWrite, MEM_Branch, MEM_Uncondbranch, MEM_CBNZSig, WB_Valid,
                           WB_RegWrite, WB_MemToReg, WB_BL, WB_Rd, StallCount}, 0);
        chk("reset_outs_s", {s_stall, s_flush, s_ex_valid, s_ex_alusrc, s_ex_illegal, s_ex_aluop, s_ex_rd,
                             s_mem_valid, s_mem_memread, s_mem_memwrite, s_mem_branch, s_mem_uncond, s_mem_cbnz,
                             s_wb_valid, s_wb_regwrite, s_wb_memtoreg, s_wb_bl, s_wb_rd, s_stall_count}, 0);
        Reset = 1'b0;
        @(negedge CLK);

        // Single LDUR through every stage.
        issue(ld3, 1, 1, 1, 0);
        chk("s1_no_stall", Stall, 0);
        idle(1);
        chk("s1_ex_alusrc", EX_ALUSrc, 1);
        chk("s1_ex_aluop", EX_ALUOp, 0);
        idle(1);
        chk("s1_mem_memread", MEM_MemRead, 1);
        idle(1);
        chk("s1_wb", {WB_RegWrite, WB_MemToReg, WB_Rd}, {2'b11, 5'd3});
        idle(2);

        // Load-use on Rn: one stall cycle, bubble, ADD one cycle late.
        issue(ld5, 1, 1, 1, 0);
        issue(add5, 0, 0, 0, 0);
        chk("s2_stall", Stall, 1);
        issue(add5, 1, 1, 1, 0);
        chk("s2_stall_off", Stall, 0);
        chk("s2_bubble", EX_Valid, 0);
        chk("s2_count", StallCount, 1);
        idle(1);
        chk("s2_add_in_ex", EX_Valid, 1);
        idle(3);

        // XZR destination never stalls and never writes.
        issue(ld31, 1, 1, 1, 0);
        issue(add31, 1, 1, 1, 0);
        chk("s3_no_stall", Stall, 0);
        idle(2);
        chk("s3_wb_regwrite", WB_RegWrite, 0);
        idle(2);
        chk("s3_count", StallCount, 1);

        // Flush beats a simultaneous load-use hazard and squashes EX and MEM.
        issue(ld5, 1, 0, 0, 0);
        issue(add5, 0, 0, 0, 1);
        chk("s4_stall", Stall, 0);
        chk("s4_flush", Flush, 1);
        idle(1);
        chk("s4_valids", {EX_Valid, MEM_Valid}, 0);
        idle(3);
        chk("s4_count", StallCount, 1);

        // BL and illegal opcode.
        issue(bl7, 1, 1, 1, 0);
        issue(ill, 1, 1, 1, 0);
        idle(1);
        chk("s5_illegal", EX_IllegalOp, 1);
        chk("s5_ill_others", {EX_ALUSrc, EX_ALUOp}, 0);
        chk("s5_ill_no_stall_flush", {Stall, Flush}, 0);
        idle(1);
        chk("s5_bl_wb", {WB_RegWrite, WB_BL, WB_Rd}, {2'b11, 5'd30});
        idle(3);

        // Remaining opcode classes back to back.
        issue(cbz, 1, 1, 1, 0);
        issue(cbnz, 1, 1, 1, 0);
        issue(stur, 1, 1, 1, 0);
        issue(addi, 1, 1, 1, 0);
        issue(lsl, 1, 1, 1, 0);
        issue(b0, 1, 1, 1, 0);
        idle(4);

        // Hazard through Rs2 (STUR), and none for B whose fields merely match.
        issue(ld12, 1, 1, 1, 0);
        issue(stur12, 0, 0, 0, 0);
        chk("rs2_stall", Stall, 1);
        issue(stur12, 1, 1, 1, 0);
        issue(ld12, 1, 1, 1, 0);
        issue(b12, 1, 1, 1, 0);
        chk("b_no_stall", Stall, 0);
        idle(4);
        chk("rs2_count", StallCount, 2);

        // Reset mid-flight with a live hazard and BranchTaken: outputs silenced, work discarded.
        issue(ld5, 1, 1, 1, 0);
        @(posedge CLK); #1;
        Reset = 1'b1; ID_Valid = 1'b1; Opcode = add5.op; Rn = add5.rn; Rs2 = add5.rs2; Rd = add5.rd;
        BranchTaken = 1'b1;
        q_ex.delete(); q_mem.delete(); q_wb.delete();
        @(negedge CLK);
        chk("rst_stall_flush", {Stall, Flush}, 0);
        @(posedge CLK); #1;
        Reset = 1'b0; ID_Valid = 1'b0; BranchTaken = 1'b0;
        chk("rst_clear", {EX_Valid, MEM_Valid, WB_Valid, StallCount}, 0);
        @(negedge CLK);
        idle(4);

        // Dependent LDUR chain: five stall cycles, 2-bit counter saturates at 3.
        issue(ld5, 1, 1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            issue(ld5d, 0, 0, 0, 0);
            chk("chain_stall", {Stall, s_stall}, 2'b11);
            issue(ld5d, 1, 1, 1, 0);
            chk("chain_go", {Stall, s_stall}, 2'b00);
        end
        idle(4);
        chk("s6_count16", StallCount, 5);
        chk("s6_count_sat", s_stall_count, 3);

        chk("sb_drain", q_ex.size() + q_mem.size() + q_wb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_pipeline.md
CONTROL_PIPELINE -- requirements
Module: control_pipeline

Interface
REQ-001 Parameters (name, default, meaning):
- REG_W, 5: register-index width.
- LINK_REG, 30: BL destination.
- ZERO_REG, 31: XZR index, never a hazard source, writes suppressed.
- BRANCH_STAGE, 2: stage where BranchTaken resolves (1=EX, 2=MEM).
- SCNT_W, 16: stall-counter width.
REQ-002 Ports (name, direction, width, meaning):
- CLK, in, 1: sole clock.
- Reset, in, 1: synchronous, active-high.
- ID_Valid, in, 1: valid instruction in ID.
- Opcode, in, 11: instruction bits [31:21].
- Rn, in, REG_W: first source.
- Rs2, in, REG_W: second source, after Reg2Loc mux.
- Rd, in, REG_W: destination field.
- BranchTaken, in, 1: taken branch/jump in stage BRANCH_STAGE.
- Stall, out, 1: hold PC and IF/ID.
- Flush, out, 1: kill IF/ID.
- EX_Valid, EX_ALUSrc, EX_IllegalOp, out, 1 each.
- EX_ALUOp, out, 2.
- EX_Rd, out, REG_W.
- MEM_Valid, MEM_MemRead, MEM_MemWrite, MEM_Branch, MEM_Uncondbranch, MEM_CBNZSig, out, 1 each.
- WB_Valid, WB_RegWrite, WB_MemToReg, WB_BL, out, 1 each.
- WB_Rd, out, REG_W.
- StallCount, out, SCNT_W: saturating stall counter.

Function
REQ-003 Decode is combinational in ID. Priority top-down:
- B 000101xxxxx: Uncondbranch=1.
- BL 100101xxxxx: Uncondbranch=1, BL=1, RegWrite=1, Rd forced to LINK_REG.
- CBZ 10110100xxx: Branch=1, ALUOp=01, uses Rs2.
- CBNZ 10110101xxx: CBNZSig=1, ALUOp=01, uses Rs2.
- LSL/LSR 1101001101x: ALUSrc=1, ALUOp=10, RegWrite=1, uses Rn.
- ADDI/SUBI x0x1000100x: ALUSrc=1, ALUOp=10, RegWrite=1, uses Rn.
- R-type 1xx0101x000: ALUOp=10, RegWrite=1, uses Rn and Rs2.
- LDUR 11111000010: ALUSrc=1, MemRead=1, MemToReg=1, RegWrite=1, uses Rn.
- STUR 11111000000: ALUSrc=1, MemWrite=1, uses Rn and Rs2.
- Unlisted signals are 0. Default: all controls 0, ALUOp=00, IllegalOp=1.
REQ-004 ID/EX, EX/MEM and MEM/WB registers carry the control bundle plus Rd and Valid. Latency: ID to EX_* is 1 cycle, to MEM_* 2 cycles, to WB_* 3 cycles.
REQ-005 Every control output SHALL be 0 whenever its stage Valid is 0 (gated). EX_Rd and WB_Rd hold their last values.
REQ-006 WB_RegWrite SHALL be 0 when WB_Rd==ZERO_REG.
REQ-007 Load-use hazard, combinational:
- Condition: ID_Valid & EX_Valid & EX MemRead & EX_Rd!=ZERO_REG & ((usesRn & EX_Rd==Rn) | (usesRs2 & EX_Rd==Rs2)).
- Response: Stall=1, and ID/EX captures a bubble (Valid=0).
REQ-008 Flush = BranchTaken, combinational. IF/ID is killed and ID/EX captures a bubble. When BRANCH_STAGE=2, EX/MEM also captures a bubble.
REQ-009 Flush has priority over the hazard: when BranchTaken=1, Stall=0.
REQ-010 EX/MEM and MEM/WB always advance; no back-pressure downstream of ID.
REQ-011 StallCount increments in each cycle with Stall=1 and saturates at all-ones.
REQ-012 EX_IllegalOp SHALL be 1 only for a valid, undecoded instruction. It does not stall or flush.

Reset
REQ-013 When Reset=1 at a CLK edge:
- All Valid bits, control outputs, EX_Rd, WB_Rd and StallCount become 0.
- Stall and Flush are forced to 0 during Reset.
REQ-014 Reset mid-operation discards all in-flight instructions. No output asserts until a new ID_Valid instruction propagates.

Verification
REQ-015 Scenario 1, reset then single instruction: ID_Valid=1, Opcode=11111000010 (LDUR), Rd=3.
- Next cycle: EX_ALUSrc=1, EX_ALUOp=00.
- +1 cycle: MEM_MemRead=1.
- +2 cycles: WB_RegWrite=1, WB_MemToReg=1, WB_Rd=3.
REQ-016 Scenario 2, load-use: LDUR Rd=5, then ADD with Rn=5 while the LDUR is in EX.
- Stall=1 for exactly 1 cycle; StallCount=1.
- A bubble is observed with EX_Valid=0; the ADD reaches EX one cycle later.
REQ-017 Scenario 3, hazard on XZR: LDUR Rd=31 followed by ADD Rn=31.
- Stall stays 0.
- WB_RegWrite=0 for the LDUR.
REQ-018 Scenario 4, flush precedence: BRANCH_STAGE=2, BranchTaken=1 in the same cycle as a load-use hazard.
- Stall=0, Flush=1.
- The following cycle: EX_Valid=0, MEM_Valid=0.
REQ-019 Scenario 5, BL and illegal opcode:
- BL with Rd=7: WB_Rd=30, WB_BL=1, WB_RegWrite=1.
- Opcode=00000000000: EX_IllegalOp=1, all other controls 0.
REQ-020 Scenario 6, counter saturation: SCNT_W=2, hold the hazard for 5 cycles -> StallCount=3.
